inst_disp_scheduler: RTL

//  Time-shares one combinational instruction disassembler (32-bit code -> 19-char ASCII) among
//  NUM_SLOTS pipeline-stage instruction registers (IF/ID/EX/MEM/WB) for the debug text display.
//  Per refresh: snapshots all slot codes, feeds each in turn to the decoder, registers the result,

---
 rtl/inst_disp_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/inst_disp_scheduler.sv
// Purpose : time-shares one combinational disassembler across NUM_SLOTS pipeline taps and streams the text into the display buffer.
// Latency : trigger -> first wr_en after 3 cycles (SNAP, ISSUE, LOAD); a full frame takes NUM_SLOTS*(2+CHARS)+2 cycles.
// Backpr. : wr_en/wr_addr/wr_data hold while wr_ready is low; triggers arriving while busy merge into one pending frame.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   slot_code         packed slot codes, slot k at [32k+31:32k]; snapshotted at frame start
//   refresh           manual refresh pulse (auto tick every REFRESH_CYC cycles, 0 disables it)
//   dec_code/dec_inst shared disassembler request and its combinational CHARS*8 ASCII result
//   wr_en/wr_ready    char write handshake toward the text buffer; wr_addr = slot*CHARS + char_idx
//   wr_data           current char, char 0 is the most significant byte of the decoded string
//   busy, frame_done  busy outside IDLE; frame_done pulses for one cycle at the end of each frame
//
// Option: define DISP_SKIP_UNCHANGED_EN to skip slots whose code matches the one last fully written.
module inst_disp_scheduler #(
  parameter int NUM_SLOTS   = 5,
  parameter int CHARS       = 19,
  parameter int ADDR_W      = 7,   // NUM_SLOTS*CHARS must fit in 2**ADDR_W
  parameter int REFRESH_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SLOTS*32-1:0] slot_code,
  input  logic                    refresh,
  output logic [31:0]             dec_code,
  input  logic [CHARS*8-1:0]      dec_inst,
  output logic                    wr_en,
  input  logic                    wr_ready,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [7:0]              wr_data,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = (CHARS > 1) ? $clog2(CHARS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_ISSUE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 pending;
  logic [SW-1:0]        slot;
  logic [CW-1:0]        char_idx;
  logic [CHARS*8-1:0]   str;
  logic [31:0]          shadow [NUM_SLOTS];
  logic [7:0]           cur_char;
  logic                 tick;
  logic                 trig;
  logic                 accept;
  logic                 last_char;
  logic                 last_slot;
  logic                 skip_hit;

  // Free-running refresh tick; keeps counting in every state.
  generate
    if (REFRESH_CYC > 0) begin : g_tick
      localparam int TW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
      logic [TW-1:0] tick_cnt;
      assign tick = (tick_cnt == TW'(REFRESH_CYC - 1));
      always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
      end
    end else begin : g_no_tick
      assign tick = 1'b0;
    end
  endgenerate

  assign trig      = refresh | tick;
  assign accept    = wr_en & wr_ready;
  assign last_char = (char_idx == CW'(CHARS - 1));
  assign last_slot = (slot == SW'(NUM_SLOTS - 1));

`ifdef DISP_SKIP_UNCHANGED_EN
  // Code last fully written per slot; valid only once the slot's final char was accepted.
  logic [31:0]          last_code [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] last_vld;

  assign skip_hit = last_vld[slot] && (last_code[slot] == shadow[slot]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_SLOTS; k++) last_code[k] <= '0;
      last_vld <= '0;
    end else if (accept && last_char) begin
      last_code[slot] <= shadow[slot];
      last_vld[slot]  <= 1'b1;
    end
  end
`else
  assign skip_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trig || pending) state_nxt = S_SNAP;
      S_SNAP:  state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (skip_hit) state_nxt = last_slot ? S_DONE : S_ISSUE;
        else          state_nxt = S_LOAD;
      end
      S_LOAD:  state_nxt = S_WRITE;
      S_WRITE: if (accept && last_char) state_nxt = last_slot ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 1'b0;
      slot     <= '0;
      char_idx <= '0;
      str      <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) shadow[k] <= '0;
    end else begin
      // IDLE always consumes the pending request (it starts a frame if set);
      // any other state, DONE included, records a trigger for later.
      if (state == S_IDLE) pending <= 1'b0;
      else if (trig)       pending <= 1'b1;

      case (state)
        S_SNAP: begin
          for (int k = 0; k < NUM_SLOTS; k++) shadow[k] <= slot_code[32*k +: 32];
        end
        S_ISSUE: begin
          if (skip_hit) slot <= last_slot ? '0 : slot + 1'b1;
        end
        S_LOAD: begin
          str      <= dec_inst;
          char_idx <= '0;
        end
        S_WRITE: begin
          if (accept) begin
            if (last_char) begin
              char_idx <= '0;
              slot     <= last_slot ? '0 : slot + 1'b1;
            end else begin
              char_idx <= char_idx + 1'b1;
            end
          end
        end
        S_DONE:  slot <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    cur_char = 8'h00;
    for (int i = 0; i < CHARS; i++) begin
      if (char_idx == CW'(i)) cur_char = str[8*(CHARS-1-i) +: 8];
    end
  end

  // slot is stable from ISSUE through WRITE, so the decoder input needs no extra register.
  assign dec_code   = (state == S_ISSUE || state == S_LOAD || state == S_WRITE) ? shadow[slot] : 32'h0;
  assign wr_en      = (state == S_WRITE);
  assign wr_addr    = wr_en ? (ADDR_W'(slot) * ADDR_W'(CHARS) + ADDR_W'(char_idx)) : '0;
  assign wr_data    = wr_en ? cur_char : 8'h00;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

endmodule
